// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame FSM states, scancode prefixes and the buffered scancode entry.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] data;
  } ps2_code_t;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// First-word-fall-through scancode FIFO; head visible the cycle after a push into empty.
// A push while full is ignored unless a pop happens in the same cycle.
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_sys,
  input  logic      reset,
  input  logic      push,
  input  ps2_code_t push_dat,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output ps2_code_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ps2_code_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + deglitch, 11-bit deframing, E0/F0 folding, scancode FIFO.
// Scancode reaches code_valid 3 cycles after the stop-bit fall strobe; full FIFO drops and pulses overflow.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       code_valid,
  output logic [7:0] code_data,
  output logic       code_ext,
  output logic       code_release,
  input  logic       code_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       busy
);

  localparam int TMO_TERM = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TMO_W    = $clog2(TMO_TERM) + 1;
  localparam int FLT_W    = $clog2(FILTER_LEN) + 1;

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_filt;
  logic             dat_filt;
  logic [FLT_W-1:0] clk_run;
  logic [FLT_W-1:0] dat_run;
  logic             clk_filt_d;
  logic             fall;

  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_bit;
  logic [TMO_W-1:0] tmo_cnt;
  logic             byte_vld;
  logic [7:0]       byte_dat;

  logic             ext_flag;
  logic             rel_flag;
  logic             push_vld;
  ps2_code_t        push_dat;

  logic             fifo_full;
  logic             fifo_empty;
  ps2_code_t        fifo_head;
  logic             pop;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // A filtered line flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      clk_run  <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_run <= '0;
    end else if (clk_run == FLT_W'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      clk_run  <= '0;
    end else begin
      clk_run <= clk_run + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dat_filt <= 1'b1;
      dat_run  <= '0;
    end else if (dat_sync[1] == dat_filt) begin
      dat_run <= '0;
    end else if (dat_run == FLT_W'(FILTER_LEN - 1)) begin
      dat_filt <= dat_sync[1];
      dat_run  <= '0;
    end else begin
      dat_run <= dat_run + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_filt_d <= 1'b1;
      fall       <= 1'b0;
    end else begin
      clk_filt_d <= clk_filt;
      fall       <= clk_filt_d & ~clk_filt;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      byte_vld   <= 1'b0;
      byte_dat   <= '0;
    end else begin
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      byte_vld   <= 1'b0;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;

      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_filt) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              err_frame <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {dat_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_filt;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_filt) begin
              err_frame <= 1'b1;
            end else if (!odd_parity_ok(shift, par_bit)) begin
              err_parity <= 1'b1;
            end else begin
              byte_vld <= 1'b1;
              byte_dat <= shift;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tmo_cnt == TMO_W'(TMO_TERM - 1)) begin
        state     <= IDLE;
        err_frame <= 1'b1;
      end
    end
  end

  // Any error or dropped byte invalidates a pending E0/F0 prefix.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      if (err_frame || err_parity || overflow) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_vld) begin
        if (byte_dat == PS2_PFX_EXT) begin
          ext_flag <= 1'b1;
        end else if (byte_dat == PS2_PFX_REL) begin
          rel_flag <= 1'b1;
        end else begin
          push_vld <= 1'b1;
          push_dat <= '{rel: rel_flag, ext: ext_flag, data: byte_dat};
          ext_flag <= 1'b0;
          rel_flag <= 1'b0;
        end
      end
    end
  end

  assign pop = ~fifo_empty & code_ready;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= push_vld & fifo_full & ~pop;
  end

  ps2_code_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign code_valid   = ~fifo_empty;
  assign code_data    = fifo_head.data;
  assign code_ext     = fifo_head.ext;
  assign code_release = fifo_head.rel;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: PS/2 frames driven at 12.5 kHz against a 1 MHz core clock,
// received scancodes compared with a prefix-folding reference queue.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int HALF_NS = 500;
  localparam int TMO_CYC = 200;
  localparam int PS2_HALF = 40;

  logic       CLK_50M = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       code_ready;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_ext;
  logic       code_release;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;
  logic       busy;

  always #(HALF_NS) CLK_50M = ~CLK_50M;

  ps2_kbd_rx #(
    .CLK_HZ     (1_000_000),
    .FILTER_LEN (8),
    .TIMEOUT_US (200),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys      (CLK_50M),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .code_valid   (code_valid),
    .code_data    (code_data),
    .code_ext     (code_ext),
    .code_release (code_release),
    .code_ready   (code_ready),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .overflow     (overflow),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int n_perr, n_ferr, n_ovf, n_vld, n_clash;
  int cyc = 0;
  int last_fall_cyc = 0;
  int ferr_cyc = 0;

  logic m_ext, m_rel;
  int   exp_perr, exp_ovf, occ;

  always @(negedge CLK_50M) begin
    cyc++;
    if (!reset) begin
      if (err_parity) n_perr++;
      if (err_frame) begin
        n_ferr++;
        ferr_cyc = cyc;
      end
      if (overflow) n_ovf++;
      if (int'(err_parity) + int'(err_frame) + int'(overflow) > 1) n_clash++;
      if (code_valid) n_vld++;
      if (code_valid && code_ready) got_q.push_back({code_release, code_ext, code_data});
    end
  end

  initial begin
    #(64'd200_000 * 64'd1000);
    $display("FAIL watchdog: simulation did not finish, cycles=%0d limit=200000", cyc);
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK_50M);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    n_perr = 0; n_ferr = 0; n_ovf = 0; n_vld = 0;
    exp_perr = 0; exp_ovf = 0; occ = 0;
  endtask

  // Reference: what a keyboard consumer should see for one byte sent on the wire.
  task automatic model_byte(input logic [7:0] b, input bit bad_par);
    if (bad_par) begin
      exp_perr++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      if (!code_ready && occ == 4) begin
        exp_ovf++;
      end else begin
        exp_q.push_back({m_rel, m_ext, b});
        if (!code_ready) occ++;
      end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic v, input int half);
    ps2_dat = v;
    wait_cyc(half);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input int half);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(f[i], half);
    ps2_dat = 1'b1;
    wait_cyc(half + 20);
    model_byte(b, bad_par);
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; code_ready = 1'b1;
    m_ext = 1'b0; m_rel = 1'b0;
    clear_obs();
    wait_cyc(5);
    n_checks++;
    if ({code_valid, code_data, code_ext, code_release} !== 11'h0)
      $display("FAIL reset_code_outputs: got %h want 000", {code_valid, code_data, code_ext, code_release});
    else n_pass++;
    n_checks++;
    if ({err_parity, err_frame, overflow, busy} !== 4'b0)
      $display("FAIL reset_status: got %b want 0000", {err_parity, err_frame, overflow, busy});
    else n_pass++;
    reset = 1'b0;
    wait_cyc(30);
    n_checks++;
    if (n_ferr + n_perr + n_vld !== 0)
      $display("FAIL reset_idle_quiet: got %0d events want 0", n_ferr + n_perr + n_vld);
    else n_pass++;
  endtask

  task automatic test_single();
    clear_obs();
    send(8'h1C, 1'b0, PS2_HALF);
    n_checks++;
    if (n_vld !== 1) $display("FAIL single_valid_cycles: got %0d want 1", n_vld);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL single_count: got %0d want 1", got_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_q[0] !== 10'h01C) $display("FAIL single_code: got %h want 01c", got_q[0]);
      else n_pass++;
    end
    n_checks++;
    if (n_perr + n_ferr + n_ovf !== 0) $display("FAIL single_errors: got %0d want 0", n_perr + n_ferr + n_ovf);
    else n_pass++;
  endtask

  task automatic test_prefix();
    clear_obs();
    send(8'hE0, 1'b0, PS2_HALF);
    send(8'hF0, 1'b0, PS2_HALF);
    send(8'h75, 1'b0, PS2_HALF);
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL prefix_count: got %0d want 1", got_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_q[0] !== 10'h375) $display("FAIL prefix_code: got %h want 375", got_q[0]);
      else n_pass++;
    end
    send(8'h1C, 1'b0, PS2_HALF);
    n_checks++;
    if (got_q.size() !== 2) $display("FAIL prefix_follow_count: got %0d want 2", got_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_q[1] !== 10'h01C) $display("FAIL prefix_flags_cleared: got %h want 01c", got_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_parity();
    clear_obs();
    send(8'h1C, 1'b1, PS2_HALF);
    n_checks++;
    if (n_perr !== 1) $display("FAIL parity_pulse: got %0d want 1", n_perr);
    else n_pass++;
    n_checks++;
    if (n_vld !== 0 || n_ferr !== 0) $display("FAIL parity_discard: got vld=%0d ferr=%0d want 0/0", n_vld, n_ferr);
    else n_pass++;
    send(8'h1C, 1'b0, PS2_HALF);
    n_checks++;
    if (got_q.size() !== 1) $display("FAIL parity_recover_count: got %0d want 1", got_q.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_q[0] !== 10'h01C) $display("FAIL parity_recover_code: got %h want 01c", got_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int dt;
    clear_obs();
    f = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 5; i++) drive_bit(f[i], PS2_HALF);
    ps2_dat = 1'b1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL timeout_busy_mid: got %b want 1", busy);
    else n_pass++;
    wait_cyc(260 - PS2_HALF);
    m_ext = 1'b0; m_rel = 1'b0;
    dt = ferr_cyc - last_fall_cyc;
    n_checks++;
    if (n_ferr !== 1) $display("FAIL timeout_pulse_count: got %0d want 1", n_ferr);
    else n_pass++;
    n_checks++;
    if (dt < TMO_CYC || dt > TMO_CYC + 30)
      $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", dt, TMO_CYC, TMO_CYC + 30);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_busy_after: got %b want 0", busy);
    else n_pass++;
    got_q.delete();
    send(8'h2A, 1'b0, PS2_HALF);
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== 10'h02A)
      $display("FAIL timeout_recover: got %0d entries head %h want 1 entry 02a", got_q.size(), got_q.size() ? got_q[0] : 10'h0);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    clear_obs();
    code_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(codes[i], 1'b0, PS2_HALF);
    n_checks++;
    if (n_ovf !== 0) $display("FAIL overflow_early: got %0d want 0", n_ovf);
    else n_pass++;
    send(codes[4], 1'b0, PS2_HALF);
    n_checks++;
    if (n_ovf !== exp_ovf) $display("FAIL overflow_pulse: got %0d want %0d", n_ovf, exp_ovf);
    else n_pass++;
    n_checks++;
    if (code_valid !== 1'b1 || code_data !== 8'h11)
      $display("FAIL overflow_head: got valid=%b data=%h want 1/11", code_valid, code_data);
    else n_pass++;
    code_ready = 1'b1;
    occ = 0;
    wait_cyc(10);
    n_checks++;
    if (code_valid !== 1'b0) $display("FAIL overflow_drained: got %b want 0", code_valid);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL overflow_count: got %0d want %0d", got_q.size(), exp_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL overflow_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch_reset();
    logic [10:0] f;
    clear_obs();
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    n_checks++;
    if (n_ferr !== 0 || busy !== 1'b0) $display("FAIL glitch_ignored: got ferr=%0d busy=%b want 0/0", n_ferr, busy);
    else n_pass++;
    f = {1'b1, ~^8'h33, 8'h33, 1'b0};
    for (int i = 0; i < 4; i++) drive_bit(f[i], PS2_HALF);
    ps2_dat = 1'b1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b want 1", busy);
    else n_pass++;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    m_ext = 1'b0; m_rel = 1'b0;
    wait_cyc(30);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy_after: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (n_ferr + n_perr + n_vld !== 0) $display("FAIL reset_mid_quiet: got %0d events want 0", n_ferr + n_perr + n_vld);
    else n_pass++;
    send(8'h5A, 1'b0, PS2_HALF);
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== 10'h05A)
      $display("FAIL reset_mid_recover: got %0d entries head %h want 1 entry 05a", got_q.size(), got_q.size() ? got_q[0] : 10'h0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad;
    int r;
    clear_obs();
    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 7) == 0);
      send(b, bad, $urandom_range(30, 50));
    end
    n_checks++;
    if (n_perr !== exp_perr) $display("FAIL random_parity_count: got %0d want %0d", n_perr, exp_perr);
    else n_pass++;
    n_checks++;
    if (n_ferr !== 0) $display("FAIL random_frame_errors: got %0d want 0", n_ferr);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL random_code[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_clash = 0;
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    test_random();
    n_checks++;
    if (n_clash !== 0) $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", n_clash);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
